// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM stage of the RV32 5-stage pipeline. Issues loads/stores
//                on a req/ack data bus, aligns and extends load data, builds
//                store strobes/lanes, stalls the front of the pipe while an
//                access is outstanding and flags misaligned/timed-out accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic        memtoReg_in,
  input  logic        regWrite_in,
  input  logic        branch_in,
  input  logic        zero_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALU_res_in,
  input  logic [31:0] rd2_in,
  input  logic [31:0] immAddress_in,
  input  logic [4:0]  rd_in,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_err,
  output logic        memtoReg_out,
  output logic        regWrite_out,
  output logic [31:0] read_data_out,
  output logic [31:0] ALU_res_out,
  output logic [4:0]  rd_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_off;
  logic [2:0]       r_funct3;
  logic [31:0]      r_cap;
  logic             r_tmo;

  logic             w_mem_op;
  logic             w_bad;
  logic [3:0]       w_strb;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ext;

  assign w_mem_op  = memRead_in | memWrite_in;
  assign pc_src    = branch_in & zero_in;
  assign pc_target = immAddress_in;
  // Front of the pipe holds while an access is being launched or is in flight.
  assign stall_out = ((r_state == S_IDLE) && w_mem_op && !w_bad) || (r_state == S_REQ);

  // Illegal size codes (stores have no unsigned forms) and misaligned H/W.
  always_comb begin
    w_bad = 1'b0;
    case (funct3_in)
      3'b000:  w_bad = 1'b0;
      3'b001:  w_bad = ALU_res_in[0];
      3'b010:  w_bad = (ALU_res_in[1:0] != 2'b00);
      3'b100:  w_bad = memWrite_in;
      3'b101:  w_bad = memWrite_in | ALU_res_in[0];
      default: w_bad = 1'b1;
    endcase
  end

  // Store lane replication and byte enables from size and address offset.
  always_comb begin
    w_strb  = 4'b1111;
    w_wdata = rd2_in;
    case (funct3_in[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << ALU_res_in[1:0];
        w_wdata = {4{rd2_in[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << {ALU_res_in[1], 1'b0};
        w_wdata = {2{rd2_in[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = rd2_in;
      end
    endcase
  end

  // Select the addressed lane of the returned word and sign/zero extend it.
  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_off)
      2'd0: w_byte = dmem_rdata[7:0];
      2'd1: w_byte = dmem_rdata[15:8];
      2'd2: w_byte = dmem_rdata[23:16];
      2'd3: w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = dmem_rdata;
    endcase
  end

  // Access FSM, bus outputs, timeout counter and the MEM/WB register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_off         <= 2'd0;
      r_funct3      <= 3'd0;
      r_cap         <= 32'd0;
      r_tmo         <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'd0;
      dmem_wdata    <= 32'd0;
      dmem_wstrb    <= 4'd0;
      mem_err       <= 1'b0;
      memtoReg_out  <= 1'b0;
      regWrite_out  <= 1'b0;
      read_data_out <= 32'd0;
      ALU_res_out   <= 32'd0;
      rd_out        <= 5'd0;
    end else begin
      mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          memtoReg_out  <= memtoReg_in;
          ALU_res_out   <= ALU_res_in;
          rd_out        <= rd_in;
          read_data_out <= 32'd0;
          if (!w_mem_op) begin
            regWrite_out <= regWrite_in;
          end else if (w_bad) begin
            regWrite_out <= 1'b0;
            mem_err      <= 1'b1;
          end else begin
            regWrite_out <= 1'b0;
            memtoReg_out <= 1'b0;
            dmem_req     <= 1'b1;
            dmem_we      <= memWrite_in;
            dmem_addr    <= {ALU_res_in[31:2], 2'b00};
            dmem_wdata   <= w_wdata;
            dmem_wstrb   <= memWrite_in ? w_strb : 4'd0;
            r_off        <= ALU_res_in[1:0];
            r_funct3     <= funct3_in;
            r_cap        <= 32'd0;
            r_tmo        <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          regWrite_out <= 1'b0;
          memtoReg_out <= 1'b0;
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            r_cap    <= dmem_we ? 32'd0 : w_ext;
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end else if (r_cnt == c_cnt_last) begin
            dmem_req <= 1'b0;
            mem_err  <= 1'b1;
            r_tmo    <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          memtoReg_out  <= memtoReg_in;
          regWrite_out  <= regWrite_in & ~r_tmo;
          ALU_res_out   <= ALU_res_in;
          rd_out        <= rd_in;
          read_data_out <= r_cap;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage; expected MEM/WB results
//                are queued when an instruction is driven and compared when
//                the stage hands it on.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memRead_in, memWrite_in, memtoReg_in, regWrite_in;
  logic        branch_in, zero_in;
  logic [2:0]  funct3_in;
  logic [31:0] ALU_res_in, rd2_in, immAddress_in;
  logic [4:0]  rd_in;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_err, memtoReg_out, regWrite_out;
  logic [31:0] read_data_out, ALU_res_out;
  logic [4:0]  rd_out;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] alu;
  } wb_t;

  wb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .memRead_in(memRead_in), .memWrite_in(memWrite_in),
    .memtoReg_in(memtoReg_in), .regWrite_in(regWrite_in),
    .branch_in(branch_in), .zero_in(zero_in), .funct3_in(funct3_in),
    .ALU_res_in(ALU_res_in), .rd2_in(rd2_in), .immAddress_in(immAddress_in),
    .rd_in(rd_in), .pc_src(pc_src), .pc_target(pc_target),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_err(mem_err),
    .memtoReg_out(memtoReg_out), .regWrite_out(regWrite_out),
    .read_data_out(read_data_out), .ALU_res_out(ALU_res_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd_, input logic wr, input logic m2r, input logic rw,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rdest);
    memRead_in  = rd_;
    memWrite_in = wr;
    memtoReg_in = m2r;
    regWrite_in = rw;
    funct3_in   = f3;
    ALU_res_in  = addr;
    rd2_in      = wd;
    rd_in       = rdest;
  endtask

  // One instruction through MEM: ack_at = REQ cycle number that sees ack (0: never).
  task automatic run_op(input string tag, input logic rd_, input logic wr, input logic m2r,
                        input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rdest,
                        input int ack_at, input logic [31:0] rdata,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input logic exp_rw, input logic [31:0] exp_rdata,
                        input int exp_stall, input int exp_reqs, input int exp_errs);
    int  stalls, reqs, errs;
    bit  done, first;
    wb_t e, got;
    @(posedge clk); #1;
    drive(rd_, wr, m2r, rw, f3, addr, wd, rdest);
    e.rw = exp_rw; e.m2r = m2r; e.rd = rdest; e.rdata = exp_rdata; e.alu = addr;
    sb.push_back(e);
    stalls = 0; reqs = 0; errs = 0; done = 0; first = 1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (mem_err) errs++;
      if (dmem_req) begin
        reqs++;
        if (first) begin
          chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
          chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, wr});
          chk({tag, "_wstrb"}, {28'd0, dmem_wstrb}, {28'd0, exp_strb});
          if (wr) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
          first = 0;
        end
        dmem_ack   = (reqs == ack_at);
        dmem_rdata = rdata;
      end else begin
        dmem_ack = 1'b0;
      end
      if (stall_out) begin
        stalls++;
      end else begin
        if (stalls > 0) chk({tag, "_bubble_rw"}, {31'd0, regWrite_out}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        if (sb.size() == 0) begin
          chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          chk({tag, "_rw"}, {31'd0, regWrite_out}, {31'd0, got.rw});
          chk({tag, "_m2r"}, {31'd0, memtoReg_out}, {31'd0, got.m2r});
          chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, got.rd});
          chk({tag, "_rdata"}, read_data_out, got.rdata);
          chk({tag, "_alu"}, ALU_res_out, got.alu);
        end
        done = 1;
      end
    end
    if (!done) chk({tag, "_no_completion"}, 32'd0, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    if (mem_err) errs++;
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    chk({tag, "_req_cycles"}, 32'(reqs), 32'(exp_reqs));
    chk({tag, "_err_pulses"}, 32'(errs), 32'(exp_errs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    branch_in = 1'b0; zero_in = 1'b0; immAddress_in = 32'h0000_4000;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_rw", {31'd0, regWrite_out}, 32'd0);
    chk("rst_rdata", read_data_out, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("pc_target", pc_target, 32'h0000_4000);
    rst_n = 1'b1;

    //      tag    rd wr m2r rw f3     addr          wd            rd  ack rdata          strb     wdata          erw  erdata       stl req err
    run_op("lw",   1, 0, 1, 1, 3'b010, 32'h100, 32'h0,        5'd5,  2, 32'hDEADBEEF, 4'b0000, 32'h0,        1, 32'hDEADBEEF, 3, 2, 0);
    run_op("lb",   1, 0, 1, 1, 3'b000, 32'h103, 32'h0,        5'd6,  1, 32'h80FFFF00, 4'b0000, 32'h0,        1, 32'hFFFFFF80, 2, 1, 0);
    run_op("lbu",  1, 0, 1, 1, 3'b100, 32'h103, 32'h0,        5'd7,  1, 32'h80FFFF00, 4'b0000, 32'h0,        1, 32'h00000080, 2, 1, 0);
    run_op("lh",   1, 0, 1, 1, 3'b001, 32'h102, 32'h0,        5'd8,  3, 32'h80011234, 4'b0000, 32'h0,        1, 32'hFFFF8001, 4, 3, 0);
    run_op("lhu",  1, 0, 1, 1, 3'b101, 32'h100, 32'h0,        5'd9,  1, 32'h1234F00D, 4'b0000, 32'h0,        1, 32'h0000F00D, 2, 1, 0);
    run_op("sh",   0, 1, 0, 0, 3'b001, 32'h102, 32'h1234ABCD, 5'd0,  1, 32'h0,        4'b1100, 32'hABCDABCD, 0, 32'h0,        2, 1, 0);
    run_op("sb",   0, 1, 0, 0, 3'b000, 32'h101, 32'h00000055, 5'd0,  2, 32'h0,        4'b0010, 32'h55555555, 0, 32'h0,        3, 2, 0);
    run_op("sw",   0, 1, 0, 0, 3'b010, 32'h104, 32'hCAFEF00D, 5'd0,  1, 32'h0,        4'b1111, 32'hCAFEF00D, 0, 32'h0,        2, 1, 0);
    run_op("lwmis",1, 0, 1, 1, 3'b010, 32'h101, 32'h0,        5'd10, 1, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        0, 0, 1);
    run_op("sbu",  0, 1, 0, 0, 3'b100, 32'h100, 32'h0,        5'd0,  1, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        0, 0, 1);
    run_op("alu",  0, 0, 0, 1, 3'b000, 32'h777, 32'h0,        5'd11, 1, 32'h0,        4'b0000, 32'h0,        1, 32'h0,        0, 0, 0);
    run_op("tmo",  1, 0, 1, 1, 3'b010, 32'h200, 32'h0,        5'd12, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,       17, 16, 0+1);

    // Reset while an access is outstanding.
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 5'd13);
    @(negedge clk);
    @(negedge clk);
    chk("abort_req_before", {31'd0, dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    branch_in = 1'b1; zero_in = 1'b1;
    #1;
    chk("abort_req", {31'd0, dmem_req}, 32'd0);
    chk("abort_addr", dmem_addr, 32'd0);
    chk("abort_rw", {31'd0, regWrite_out}, 32'd0);
    chk("abort_alu", ALU_res_out, 32'd0);
    chk("abort_rd", {27'd0, rd_out}, 32'd0);
    chk("abort_stall", {31'd0, stall_out}, 32'd0);
    chk("abort_pc_src", {31'd0, pc_src}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    branch_in = 1'b0;
    #1;
    chk("pc_src_clear", {31'd0, pc_src}, 32'd0);

    run_op("lw2",  1, 0, 1, 1, 3'b010, 32'h300, 32'h0,        5'd14, 1, 32'h0BADF00D, 4'b0000, 32'h0,        1, 32'h0BADF00D, 2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
